wb_slave_mem: RTL and testbench

- Parametrised Wishbone classic-cycle slave with on-chip word memory.
- Programmable per-transfer wait states and ERR response for out-of-range addresses.
- Clean abort when the master withdraws CYC or STB.
- Serves as the synthesizable responder behind the team's Wishbone master bench interfaces, giving assertions real ACK/ERR timing to check against.

---
 rtl/wb_slave_mem.sv | 142 ++++++++++++++
 tb/tb_wb_slave_mem.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle slave backed by an on-chip word memory.
// It supports programmable wait states and gives an ERR termination for out-of-range addresses.
module wb_slave_mem #(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int DEPTH  = 256,
  parameter int WAIT_W = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CYC,
  input  logic              STB,
  input  logic              WE,
  input  logic [AW-1:0]     ADR,
  input  logic [DW/8-1:0]   SEL,
  input  logic [DW-1:0]     DAT_I,
  input  logic [WAIT_W-1:0] WAIT_CYCLES,
  output logic [DW-1:0]     DAT_O,
  output logic              ACK,
  output logic              ERR,
  output logic              BUSY
);

  localparam int IW = $clog2(DEPTH);
  localparam int NB = DW / 8;
  localparam logic [AW:0] DEPTH_X = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t            state;
  logic [WAIT_W-1:0] cnt;
  logic [IW-1:0]     idx_q;
  logic              we_q;
  logic              ok_q;
  logic [NB-1:0]     sel_q;
  logic [DW-1:0]     dat_q;
  logic [DW-1:0]     mem [DEPTH];

  logic              req;
  logic              in_range;
  logic              enter_resp;
  logic [IW-1:0]     cur_idx;
  logic              cur_we;
  logic              cur_ok;
  logic [NB-1:0]     cur_sel;
  logic [DW-1:0]     cur_dat;

  assign req      = CYC & STB;
  assign in_range = {1'b0, ADR} < DEPTH_X;

  // Zero-wait requests respond straight from IDLE, so they use the live bus values rather than the latched copy.
  always_comb begin
    enter_resp = 1'b0;
    cur_idx    = idx_q;
    cur_we     = we_q;
    cur_ok     = ok_q;
    cur_sel    = sel_q;
    cur_dat    = dat_q;
    case (state)
      S_IDLE: begin
        cur_idx    = ADR[IW-1:0];
        cur_we     = WE;
        cur_ok     = in_range;
        cur_sel    = SEL;
        cur_dat    = DAT_I;
        enter_resp = req && (WAIT_CYCLES == '0);
      end
      S_WAIT:  enter_resp = req && (cnt == WAIT_W'(1));
      default: enter_resp = 1'b0;
    endcase
    if (RST) enter_resp = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (enter_resp && cur_we && cur_ok) begin
      for (int b = 0; b < NB; b++) begin
        if (cur_sel[b]) mem[cur_idx][8*b +: 8] <= cur_dat[8*b +: 8];
      end
    end
  end

  // Response outputs are pulses; they default low and are raised only on the edge entering RESP.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx_q <= '0;
      we_q  <= 1'b0;
      ok_q  <= 1'b0;
      sel_q <= '0;
      dat_q <= '0;
      ACK   <= 1'b0;
      ERR   <= 1'b0;
      BUSY  <= 1'b0;
      DAT_O <= '0;
    end else begin
      ACK   <= 1'b0;
      ERR   <= 1'b0;
      DAT_O <= '0;
      if (enter_resp) begin
        ACK <= cur_ok;
        ERR <= !cur_ok;
        if (!cur_we && cur_ok) DAT_O <= mem[cur_idx];
      end
      case (state)
        S_IDLE: begin
          if (req) begin
            idx_q <= ADR[IW-1:0];
            we_q  <= WE;
            ok_q  <= in_range;
            sel_q <= SEL;
            dat_q <= DAT_I;
            cnt   <= WAIT_CYCLES;
            BUSY  <= 1'b1;
            state <= (WAIT_CYCLES == '0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (!req) begin
            state <= S_IDLE;
            cnt   <= '0;
            BUSY  <= 1'b0;
          end else if (cnt == WAIT_W'(1)) begin
            state <= S_RESP;
            cnt   <= '0;
          end else begin
            cnt <= cnt - WAIT_W'(1);
          end
        end
        S_RESP: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Randomised self-checking bench for wb_slave_mem.
// It checks against a word-array memory model and the latency/termination rules.
module tb_wb_slave_mem;

  localparam int DW     = 32;
  localparam int AW     = 32;
  localparam int DEPTH  = 256;
  localparam int WAIT_W = 4;
  localparam int LOW    = 64;

  logic              CLK = 1'b0;
  logic              RST;
  logic              CYC;
  logic              STB;
  logic              WE;
  logic [AW-1:0]     ADR;
  logic [DW/8-1:0]   SEL;
  logic [DW-1:0]     DAT_I;
  logic [WAIT_W-1:0] WAIT_CYCLES;
  logic [DW-1:0]     DAT_O;
  logic              ACK;
  logic              ERR;
  logic              BUSY;

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;
  logic [31:0] model_mem [DEPTH];

  wb_slave_mem #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .WAIT_W(WAIT_W)) dut (
    .CLK(CLK), .RST(RST), .CYC(CYC), .STB(STB), .WE(WE), .ADR(ADR),
    .SEL(SEL), .DAT_I(DAT_I), .WAIT_CYCLES(WAIT_CYCLES), .DAT_O(DAT_O),
    .ACK(ACK), .ERR(ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) edge_cnt++;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One complete transfer, entered and left with the slave idle.
  // abort_at >= 0 withdraws CYC/STB that many cycles after acceptance.
  task automatic applyStimulus(input bit we, input logic [31:0] adr, input logic [3:0] sel,
                               input logic [31:0] dat, input int w, input int abort_at,
                               input bit change_w, output logic [31:0] rdata);
    bit   ok;
    bit   done;
    int   lat;
    logic got_ack;
    logic got_err;
    ok      = (adr < DEPTH);
    done    = 1'b0;
    lat     = -1;
    got_ack = 1'b0;
    got_err = 1'b0;
    rdata   = '0;
    CYC = 1'b1; STB = 1'b1; WE = we; ADR = adr; SEL = sel; DAT_I = dat;
    WAIT_CYCLES = w[WAIT_W-1:0];
    @(posedge CLK); #1;
    for (int j = 0; j <= w + 2 && !done; j++) begin
      if (change_w && j == 0) WAIT_CYCLES = '0;
      checkOutput("ack_err_excl", 64'(ACK & ERR), 64'(0));
      if (abort_at >= 0) begin
        checkOutput("abort_no_resp", 64'(ACK | ERR), 64'(0));
        if (j == abort_at + 1) checkOutput("abort_idle", 64'(BUSY), 64'(0));
        if (j == abort_at) begin
          STB = 1'b0;
          CYC = 1'b0;
        end
      end else if (ACK || ERR) begin
        lat     = j;
        got_ack = ACK;
        got_err = ERR;
        rdata   = DAT_O;
        done    = 1'b1;
        checkOutput("busy_resp", 64'(BUSY), 64'(1));
      end else begin
        checkOutput("busy_wait", 64'(BUSY), 64'(1));
      end
      if (!done) begin
        @(posedge CLK); #1;
      end
    end
    if (abort_at < 0) begin
      checkOutput("latency", 64'(lat), 64'(w));
      checkOutput("ack", 64'(got_ack), 64'(ok));
      checkOutput("err", 64'(got_err), 64'(!ok));
      if (!we) checkOutput("rdata", 64'(rdata), ok ? 64'(model_mem[adr[7:0]]) : 64'(0));
      if (we && ok) begin
        for (int b = 0; b < 4; b++)
          if (sel[b]) model_mem[adr[7:0]][8*b +: 8] = dat[8*b +: 8];
      end
      CYC = 1'b0;
      STB = 1'b0;
      @(posedge CLK); #1;
      checkOutput("resp_one_cycle", 64'({ACK, ERR, BUSY}), 64'(0));
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] adr;
    int          w;
    int          ab;
    int          r;
    int          k;
    int          ack_edges[$];

    RST = 1'b1; CYC = 1'b0; STB = 1'b0; WE = 1'b0; ADR = '0; SEL = '0;
    DAT_I = '0; WAIT_CYCLES = '0;
    repeat (2) @(posedge CLK);
    #1;
    checkOutput("reset_ack", 64'(ACK), 64'(0));
    checkOutput("reset_err", 64'(ERR), 64'(0));
    checkOutput("reset_busy", 64'(BUSY), 64'(0));
    checkOutput("reset_dat", 64'(DAT_O), 64'(0));
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int a = 0; a < LOW; a++) applyStimulus(1'b1, 32'(a), 4'hF, $urandom, 0, -1, 1'b0, rd);

    applyStimulus(1'b1, 32'd5, 4'hF, 32'hDEADBEEF, 0, -1, 1'b0, rd);
    applyStimulus(1'b0, 32'd5, 4'hF, 32'h0, 0, -1, 1'b0, rd);
    checkOutput("read_back", 64'(rd), 64'h0000_0000_DEAD_BEEF);

    applyStimulus(1'b1, 32'd7, 4'hF, 32'h11223344, 0, -1, 1'b0, rd);
    applyStimulus(1'b1, 32'd7, 4'b0101, 32'hAABBCCDD, 1, -1, 1'b0, rd);
    applyStimulus(1'b0, 32'd7, 4'hF, 32'h0, 0, -1, 1'b0, rd);
    checkOutput("lane_merge", 64'(rd), 64'h0000_0000_11BB_33DD);

    applyStimulus(1'b0, 32'd20, 4'hF, 32'h0, 3, -1, 1'b1, rd);
    applyStimulus(1'b0, 32'd256, 4'hF, 32'h0, 0, -1, 1'b0, rd);
    applyStimulus(1'b1, 32'd300, 4'hF, 32'h0BADF00D, 0, -1, 1'b0, rd);
    applyStimulus(1'b0, 32'd44, 4'hF, 32'h0, 0, -1, 1'b0, rd);
    applyStimulus(1'b1, 32'd9, 4'hF, 32'hCAFEF00D, 5, 1, 1'b0, rd);
    applyStimulus(1'b0, 32'd9, 4'hF, 32'h0, 2, -1, 1'b0, rd);

    // Reset mid-wait must cancel the pending write but keep the memory intact.
    CYC = 1'b1; STB = 1'b1; WE = 1'b1; ADR = 32'd10; SEL = 4'hF;
    DAT_I = 32'h5555AAAA; WAIT_CYCLES = 4'd4;
    @(posedge CLK); #1;
    checkOutput("rst_busy_pre", 64'(BUSY), 64'(1));
    RST = 1'b1;
    @(posedge CLK); #1;
    checkOutput("rst_ack", 64'(ACK), 64'(0));
    checkOutput("rst_err", 64'(ERR), 64'(0));
    checkOutput("rst_busy", 64'(BUSY), 64'(0));
    RST = 1'b0; CYC = 1'b0; STB = 1'b0;
    @(posedge CLK); #1;
    applyStimulus(1'b0, 32'd10, 4'hF, 32'h0, 0, -1, 1'b0, rd);
    applyStimulus(1'b0, 32'd5, 4'hF, 32'h0, 1, -1, 1'b0, rd);

    k = 0;
    CYC = 1'b1; STB = 1'b1; WE = 1'b0; WAIT_CYCLES = 4'd1; ADR = 32'd5;
    @(posedge CLK); #1;
    for (int c = 0; c < 20 && k < 3; c++) begin
      checkOutput("b2b_excl", 64'(ACK & ERR), 64'(0));
      if (ACK) begin
        ack_edges.push_back(edge_cnt);
        checkOutput("b2b_data", 64'(DAT_O), 64'(model_mem[ADR[7:0]]));
        k++;
        ADR = ADR + 32'd1;
      end
      @(posedge CLK); #1;
    end
    CYC = 1'b0; STB = 1'b0;
    @(posedge CLK); #1;
    checkOutput("b2b_count", 64'(k), 64'(3));
    if (ack_edges.size() == 3) begin
      checkOutput("b2b_gap1", 64'(ack_edges[1] - ack_edges[0]), 64'(3));
      checkOutput("b2b_gap2", 64'(ack_edges[2] - ack_edges[1]), 64'(3));
    end

    for (int n = 0; n < 150; n++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) adr = 32'(DEPTH) + $urandom_range(0, 2000);
      else if (r == 1) adr = $urandom | 32'h8000_0000;
      else adr = $urandom_range(0, LOW - 1);
      w  = ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3));
      ab = (w > 0 && $urandom_range(0, 5) == 0) ? int'($urandom_range(0, w - 1)) : -1;
      applyStimulus(1'($urandom_range(0, 1)), adr, 4'($urandom), $urandom, w, ab, 1'b0, rd);
    end

    for (int a = 0; a < 4; a++) applyStimulus(1'b0, 32'(a), 4'hF, 32'h0, 0, -1, 1'b0, rd);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
